// File: rtl/cpu_pkg.sv
// Shared CPU control-path constants used by the stack-pointer datapath blocks.
package cpu_pkg;

    // Native data / stack-pointer width of the CPU.
    localparam int DATA_W = 16;

    // Value the stack pointer takes on reset.
    // Shared with the stack-pointer register so both agree on the start point.
    localparam logic [DATA_W-1:0] SP_RESET_VAL = '0;

endpackage

// File: rtl/sp_subtractor.sv
// Registered stack-pointer decrement stage.
// When jump_enable is high, the block presents input_stack - STEP one cycle later.
// Otherwise it passes input_stack through one cycle later.
// It also flags a decrement that lands below SP_FLOOR or wraps past zero.
module sp_subtractor
    import cpu_pkg::*;
#(
    parameter int              W        = DATA_W,
    parameter int unsigned     STEP     = 1,
    parameter logic [W-1:0]    SP_RESET = W'(SP_RESET_VAL),
    parameter logic [W-1:0]    SP_FLOOR = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] input_stack,
    input  logic         jump_enable,
    output logic [W-1:0] output_stack,
    output logic         underflow
);

    // The underflow threshold is held one bit wider than the stack pointer.
    // This keeps SP_FLOOR + STEP from overflowing when the floor sits near the top of the range.
    localparam logic [W-1:0] STEP_W     = W'(STEP);
    localparam logic [W:0]   UFL_LIMIT  = {1'b0, SP_FLOOR} + {1'b0, STEP_W};

    logic [W-1:0] next_stack;
    logic         next_underflow;

    // Select between the wrapped decrement and the pass-through value.
    // Underflow is raised only on a decrement whose input sits below the floor plus one step.
    always_comb begin
        next_stack     = input_stack;
        next_underflow = 1'b0;
        if (jump_enable) begin
            next_stack     = input_stack - STEP_W;
            next_underflow = ({1'b0, input_stack} < UFL_LIMIT);
        end
    end

    // Output register.
    // It clears asynchronously on reset and otherwise takes a fresh result on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            output_stack <= SP_RESET;
            underflow    <= 1'b0;
        end else begin
            output_stack <= next_stack;
            underflow    <= next_underflow;
        end
    end

endmodule

// File: tb/tb_sp_subtractor.sv
// Directed self-checking bench for sp_subtractor with default parameters (W=16, STEP=1, floor 0).
module tb_sp_subtractor;

    logic        clk;
    logic        rst_n;
    logic [15:0] input_stack;
    logic        jump_enable;
    logic [15:0] output_stack;
    logic        underflow;

    int total;
    int bad;

    sp_subtractor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .input_stack  (input_stack),
        .jump_enable  (jump_enable),
        .output_stack (output_stack),
        .underflow    (underflow)
    );

    // 10-unit clock period; rising edges occur at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive the inputs on the falling edge, then check the outputs 1 unit after the next rising edge.
    task automatic step_and_check(input string name, input logic je, input logic [15:0] sp,
                                  input logic [15:0] exp_sp, input logic exp_uf);
        @(negedge clk);
        jump_enable = je;
        input_stack = sp;
        @(posedge clk);
        #1;
        total++;
        if (output_stack !== exp_sp) begin
            bad++;
            $display("[TB] FAIL %s output_stack: got %h expected %h", name, output_stack, exp_sp);
        end
        total++;
        if (underflow !== exp_uf) begin
            bad++;
            $display("[TB] FAIL %s underflow: got %b expected %b", name, underflow, exp_uf);
        end
    endtask

    // Check that reset clears the outputs before any clock edge, and that it holds them low across edges.
    task automatic test_reset();
        rst_n       = 1'b0;
        input_stack = 16'h1234;
        jump_enable = 1'b1;
        #1;
        total++;
        if (output_stack !== 16'h0000 || underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_immediate: got %h/%b expected 0000/0", output_stack, underflow);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (output_stack !== 16'h0000 || underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_held: got %h/%b expected 0000/0", output_stack, underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Check the pass-through path, including the all-ones boundary.
    task automatic test_pass_through();
        step_and_check("pass_1015", 1'b0, 16'h1015, 16'h1015, 1'b0);
        step_and_check("pass_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    endtask

    // Check plain decrements and the no-underflow edge at floor+step.
    task automatic test_decrement();
        step_and_check("dec_aba2", 1'b1, 16'hABA2, 16'hABA1, 1'b0);
        step_and_check("dec_0001", 1'b1, 16'h0001, 16'h0000, 1'b0);
    endtask

    // Check the wrap below zero, then check that the flag is a one-cycle pulse.
    task automatic test_wrap();
        step_and_check("wrap_0000",  1'b1, 16'h0000, 16'hFFFF, 1'b1);
        step_and_check("after_wrap", 1'b0, 16'h0005, 16'h0005, 1'b0);
    endtask

    // Check that a mid-cycle input change does not reach the output before the next edge.
    task automatic test_latency();
        step_and_check("lat_setup", 1'b0, 16'h0042, 16'h0042, 1'b0);
        @(negedge clk);
        jump_enable = 1'b1;
        input_stack = 16'h0010;
        #2;
        input_stack = 16'h0020;
        #1;
        total++;
        if (output_stack !== 16'h0042) begin
            bad++;
            $display("[TB] FAIL lat_hold: got %h expected 0042", output_stack);
        end
        @(posedge clk);
        #1;
        total++;
        if (output_stack !== 16'h001F || underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lat_edge: got %h/%b expected 001f/0", output_stack, underflow);
        end
    endtask

    // Check that an asynchronous reset between edges clears the state and overrides the pending update.
    task automatic test_async_reset();
        step_and_check("pre_reset", 1'b1, 16'hABA2, 16'hABA1, 1'b0);
        @(negedge clk);
        input_stack = 16'h0000;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (output_stack !== 16'h0000 || underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: got %h/%b expected 0000/0", output_stack, underflow);
        end
        @(posedge clk);
        #1;
        total++;
        if (output_stack !== 16'h0000 || underflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset_hold: got %h/%b expected 0000/0", output_stack, underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step_and_check("post_reset", 1'b1, 16'h0100, 16'h00FF, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_pass_through();
        test_decrement();
        test_wrap();
        test_latency();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_subtractor.md
Name: sp_subtractor

Overview:
- Registered stack-pointer decrement stage for the CPU control path.
- On a jump or call (jump_enable high), it presents the incoming stack pointer minus one step on the next clock edge.
- Otherwise it passes the stack pointer through unchanged, one cycle later.
- Also flags a stack underflow, i.e. a decrement that crosses the configured floor.

Parameters:
- W, 16, stack pointer width in bits.
- STEP, 1, decrement amount applied when jump_enable=1; must be less than 2^W.
- SP_RESET, 0, value of output_stack after reset.
- SP_FLOOR, 0, lowest legal stack pointer value; used for underflow detection.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- input_stack  input  W  current stack pointer value.
- jump_enable  input  1  1 = decrement by STEP; 0 = pass through.
- output_stack  output  W  registered resulting stack pointer.
- underflow  output  1  registered flag: the last decrement went below SP_FLOOR or wrapped.

Behaviour:
- Reset: rst_n low forces output_stack=SP_RESET and underflow=0 immediately, independent of clk. Both are held while rst_n is low.
- Reset release: the first update happens on the first rising clk edge after rst_n goes high.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N; the outputs hold until the next edge. There is no combinational path from inputs to outputs.
- jump_enable=0: output_stack <= input_stack; underflow <= 0.
- jump_enable=1: output_stack <= (input_stack - STEP) mod 2^W, i.e. wrap-around with no saturation.
- Underflow condition, evaluated with jump_enable=1: underflow <= 1 when input_stack < SP_FLOOR + STEP. This covers wrap past zero when SP_FLOOR=0.
- Underflow does not alter the arithmetic: output_stack still takes the wrapped value. Handling is the consumer's responsibility.
- Underflow pulses: the flag is 1 only for the cycle after the offending decrement and is not sticky.
- Boundaries:
  - input_stack=0, STEP=1, jump_enable=1 -> output_stack=2^W-1, underflow=1.
  - input_stack=SP_FLOOR+STEP -> no underflow.
  - input_stack=2^W-1 with jump_enable=0 -> passes through unchanged.
- Reset mid-operation: asserting rst_n between edges overrides any pending update. The next edge after release samples fresh inputs.
- No handshake. The block updates on every clock edge; there is no enable or stall input.

Decomposition:
- Shared package (cpu_pkg): W default as the data-width constant, and the stack pointer reset constant shared with the stack-pointer register.
- No sub-module: the block is a single subtractor, a comparator and an output register.

Test Plan:
1. Reset: rst_n=0 with input_stack=16'h1234 and jump_enable=1 -> output_stack=16'h0000 and underflow=0 immediately, before any edge; both held until release.
2. Pass-through: rst_n=1, jump_enable=0, input_stack=16'h1015 -> after the next rising edge output_stack=16'h1015, underflow=0.
3. Decrement: jump_enable=1, input_stack=16'hABA2 -> after the next rising edge output_stack=16'hABA1, underflow=0.
4. Wrap: jump_enable=1, input_stack=16'h0000 -> output_stack=16'hFFFF, underflow=1. The next cycle with jump_enable=0 and input_stack=16'h0005 gives output_stack=16'h0005, underflow=0.
5. Latency check: change input_stack from 16'h0010 to 16'h0020 mid-cycle with jump_enable=1 -> output_stack stays at its previous value until the edge, then shows 16'h001F.
6. Async reset mid-run: after test 3, pulse rst_n low between edges -> output_stack drops to 16'h0000 without waiting for a clock edge; after release and one edge with jump_enable=1, input_stack=16'h0100 -> 16'h00FF.
